micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Microprogram sequencer sitting directly upstream of the 32-word microcode ROM.
- Holds the micro-PC and drives the ROM address every cycle.
- Consumes the ROM's 5-bit next-address field. At the dispatch micro-step (FETCH2) it substitutes an opcode-mapped start address, resolving JMPNZ on the Z flag.
- Provides run/halt control, stall hold, illegal-opcode detection and an instruction counter for the control unit.

Parameters:
- ADDR_W, 5, micro-address width (ROM depth 32).
- OP_W, 8, opcode width from instruction register.
- DISPATCH_ADDR, 1, micro-address whose next address comes from the opcode map (FETCH2).
- ROM_WORDS, 27, number of populated ROM words; next addresses >= this are illegal.
- HALT_OP, 8'h3F, opcode that stops the sequencer.
- CNT_W, 16, instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin/resume execution from FETCH1.
- stall  in  1  hold current micro-address (memory/bus not ready).
- next_addr  in  ADDR_W  next-address field of current ROM word (cs[4:0]).
- opcode  in  OP_W  current instruction register opcode.
- z_flag  in  1  ALU zero flag, sampled at dispatch.
- addr  out  ADDR_W  micro-address to ROM (registered).
- running  out  1  high in RUN state.
- halted  out  1  high in HALT state.
- illegal_op  out  1  sticky: unmapped opcode or out-of-range next address caused halt.
- dispatch  out  1  one-cycle pulse on the cycle a new opcode is dispatched.
- instr_count  out  CNT_W  dispatched-instruction count, saturating.

Behaviour:
- States: IDLE, RUN, HALT (2-bit register).
- Reset (async): state=IDLE, addr=0, running=0, halted=0, illegal_op=0, dispatch=0, instr_count=0.
- IDLE: addr held at 0. start=1 -> RUN next edge; instr_count and illegal_op cleared; addr stays 0 so FETCH1 is presented.
- RUN, stall=1: addr, state and instr_count hold; dispatch=0. Stall has priority over every other RUN action.
- RUN, stall=0, addr!=DISPATCH_ADDR:
  - next_addr < ROM_WORDS -> addr<=next_addr.
  - next_addr >= ROM_WORDS -> HALT, illegal_op<=1, addr<=0.
- RUN, stall=0, addr==DISPATCH_ADDR: next_addr is ignored (don't-care) and addr<=map(opcode). dispatch pulses high for one cycle and instr_count increments, saturating at all-ones.
- Opcode map (hex opcode -> micro-address):
  - 00 -> 0; 01 -> 2; 02 -> 3; 03 -> 4; 04 -> 5.
  - 05 -> 10 if z_flag=0, else 13.
  - 06 -> 14; 07 -> 15; 08 -> 16; 09 -> 17; 0A -> 18; 0B -> 19; 0C -> 20.
  - 0D -> 21; 0E -> 23; 0F -> 25; 10 -> 26.
- HALT_OP at dispatch -> HALT, addr<=0, illegal_op unchanged, counted as dispatched.
- Any other opcode at dispatch -> HALT, addr<=0, illegal_op<=1, not counted, dispatch=0.
- z_flag is sampled only on the dispatch edge.
- HALT: addr=0, halted=1. start=1 -> RUN, clearing illegal_op and instr_count. stall is ignored.
- start is ignored while in RUN.
- Latency: addr updates one clock after the ROM word is presented; the ROM is combinational, so each micro-step takes one cycle.
- Outputs running and halted are decoded from the state register and are glitch-free. dispatch and addr are registered.
- rst asserted mid-instruction aborts immediately to IDLE with all outputs at their reset values.

Test Plan:
- Reset then start, opcode=0A, ROM chain 0->1 -> addr sequence 0,1,18,0,1; dispatch high exactly once in the first pass; instr_count=1 after the first dispatch.
- JMPNZ: opcode=05, z_flag=0 -> addr 1 then 10, and the chain 11,12 follows via next_addr. Repeat with z_flag=1 -> 1 then 13.
- stall held 3 cycles at addr=21 (LOAD1) -> addr stays 21 for 3 cycles, then 22; instr_count unchanged during the stall.
- opcode=3F at dispatch -> halted=1, addr=0, illegal_op=0. start -> running=1, instr_count=0.
- opcode=2A at dispatch -> halted=1, illegal_op=1, instr_count not incremented. Separately, next_addr=30 from addr=3 -> halted, illegal_op=1.
- Assert rst while in RUN at addr=16 -> same cycle asynchronously: addr=0, state IDLE, all flags 0. Also drive 65536 dispatches -> instr_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//
// Microprogram sequencer placed directly in front of a 32-word combinational
// microcode ROM. It holds the micro-PC (addr_o), follows the ROM next-address
// field, and at the dispatch micro-step (FETCH2) substitutes the start address
// of the current opcode's microroutine. It also provides run/halt control,
// stall hold, illegal-opcode / illegal-address detection and a saturating
// count of dispatched instructions.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        one-cycle request to begin/resume execution at FETCH1
//   stall_i        hold the current micro-address
//   next_addr_i    next-address field of the ROM word currently presented
//   opcode_i       instruction-register opcode, used at dispatch
//   z_flag_i       ALU zero flag, used at dispatch to resolve JMPNZ
//   addr_o         registered micro-address to the ROM
//   running_o      high in RUN
//   halted_o       high in HALT
//   illegal_op_o   sticky: halt caused by unmapped opcode or bad next address
//   dispatch_o     registered one-cycle pulse per dispatched opcode
//   instr_count_o  saturating dispatched-instruction count
// -----------------------------------------------------------------------------
module micro_sequencer #(
  parameter int unsigned       ADDR_W        = 5,
  parameter int unsigned       OP_W          = 8,
  parameter int unsigned       DISPATCH_ADDR = 1,
  parameter int unsigned       ROM_WORDS     = 27,
  parameter logic [OP_W-1:0]   HALT_OP       = 8'h3F,
  parameter int unsigned       CNT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] next_addr_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic              z_flag_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              running_o,
  output logic              halted_o,
  output logic              illegal_op_o,
  output logic              dispatch_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [ADDR_W-1:0] DISP_A    = ADDR_W'(DISPATCH_ADDR);
  // One extra bit so ROM_WORDS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   ROM_LIMIT = (ADDR_W + 1)'(ROM_WORDS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               illegal_q;
  logic               dispatch_q;
  logic [CNT_W-1:0]   count_q;

  logic               map_valid_s;
  logic [4:0]         map_addr_s;
  logic               next_bad_s;
  logic               at_dispatch_s;
  logic [CNT_W-1:0]   count_sat_d;

  // Opcode map: returns {valid, start address}. JMPNZ (05) resolves on z.
  function automatic logic [5:0] map_opcode(input logic [7:0] op, input logic z);
    logic [5:0] r;
    case (op)
      8'h00:   r = {1'b1, 5'd0};
      8'h01:   r = {1'b1, 5'd2};
      8'h02:   r = {1'b1, 5'd3};
      8'h03:   r = {1'b1, 5'd4};
      8'h04:   r = {1'b1, 5'd5};
      8'h05:   r = z ? {1'b1, 5'd13} : {1'b1, 5'd10};
      8'h06:   r = {1'b1, 5'd14};
      8'h07:   r = {1'b1, 5'd15};
      8'h08:   r = {1'b1, 5'd16};
      8'h09:   r = {1'b1, 5'd17};
      8'h0A:   r = {1'b1, 5'd18};
      8'h0B:   r = {1'b1, 5'd19};
      8'h0C:   r = {1'b1, 5'd20};
      8'h0D:   r = {1'b1, 5'd21};
      8'h0E:   r = {1'b1, 5'd23};
      8'h0F:   r = {1'b1, 5'd25};
      8'h10:   r = {1'b1, 5'd26};
      default: r = {1'b0, 5'd0};
    endcase
    return r;
  endfunction

  // Combinational decode of dispatch target, address range and counter step.
  always_comb begin
    {map_valid_s, map_addr_s} = map_opcode(8'(opcode_i), z_flag_i);
    next_bad_s    = ({1'b0, next_addr_i} >= ROM_LIMIT);
    at_dispatch_s = (addr_q == DISP_A);
    if (count_q == CNT_MAX) begin
      count_sat_d = count_q;
    end else begin
      count_sat_d = count_q + CNT_W'(1);
    end
  end

  // Sequencer FSM with registered micro-address, flags and counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      illegal_q  <= 1'b0;
      dispatch_q <= 1'b0;
      count_q    <= '0;
    end else begin
      dispatch_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          addr_q <= '0;
          if (start_i) begin
            state_q   <= ST_RUN;
            count_q   <= '0;
            illegal_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stall_i) begin
            // Stall wins over everything: hold addr, state and count.
            addr_q <= addr_q;
          end else if (at_dispatch_s) begin
            // next_addr_i is a don't-care here; the opcode decides.
            if (opcode_i == HALT_OP) begin
              state_q    <= ST_HALT;
              addr_q     <= '0;
              dispatch_q <= 1'b1;
              count_q    <= count_sat_d;
            end else if (map_valid_s) begin
              addr_q     <= ADDR_W'(map_addr_s);
              dispatch_q <= 1'b1;
              count_q    <= count_sat_d;
            end else begin
              state_q   <= ST_HALT;
              addr_q    <= '0;
              illegal_q <= 1'b1;
            end
          end else if (next_bad_s) begin
            state_q   <= ST_HALT;
            addr_q    <= '0;
            illegal_q <= 1'b1;
          end else begin
            addr_q <= next_addr_i;
          end
        end
        ST_HALT: begin
          addr_q <= '0;
          if (start_i) begin
            state_q   <= ST_RUN;
            count_q   <= '0;
            illegal_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          addr_q  <= '0;
        end
      endcase
    end
  end

  // State-decoded flags come straight from the state register (no glitches).
  assign running_o     = (state_q == ST_RUN);
  assign halted_o      = (state_q == ST_HALT);
  assign addr_o        = addr_q;
  assign illegal_op_o  = illegal_q;
  assign dispatch_o    = dispatch_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
//
// Table-driven bench for micro_sequencer. A small ROM model feeds next_addr
// from the DUT's address; each table row drives the control inputs and pushes
// its expected outputs onto a scoreboard queue, which is popped and compared
// one cycle later. A second instance with an 8-bit counter covers saturation.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

  typedef struct packed {
    logic [4:0]  addr;
    logic        run;
    logic        halt;
    logic        ill;
    logic        disp;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       start;
    logic       stall;
    logic [7:0] op;
    logic       z;
    logic       ovr;
    logic [4:0] nxt;
    exp_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        z_flag = 1'b0;
  logic [4:0]  next_addr;
  logic [4:0]  addr;
  logic        running, halted, illegal_op, dispatch;
  logic [15:0] instr_count;

  logic        ovr_en = 1'b0;
  logic [4:0]  ovr_val = 5'd0;
  logic [4:0]  rom [32];

  // Saturation instance
  logic        s_start = 1'b0;
  logic [4:0]  s_next, s_addr;
  logic        s_running, s_halted, s_ill, s_disp;
  logic [7:0]  s_cnt;

  exp_t sb[$];
  vec_t tbl1[$];
  vec_t tbl2[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  assign next_addr = ovr_en ? ovr_val : rom[addr];
  assign s_next    = (s_addr == 5'd0) ? 5'd1 : 5'd0;

  micro_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .next_addr_i(next_addr), .opcode_i(opcode), .z_flag_i(z_flag),
    .addr_o(addr), .running_o(running), .halted_o(halted),
    .illegal_op_o(illegal_op), .dispatch_o(dispatch), .instr_count_o(instr_count)
  );

  micro_sequencer #(.CNT_W(8)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .stall_i(1'b0),
    .next_addr_i(s_next), .opcode_i(8'h00), .z_flag_i(1'b0),
    .addr_o(s_addr), .running_o(s_running), .halted_o(s_halted),
    .illegal_op_o(s_ill), .dispatch_o(s_disp), .instr_count_o(s_cnt)
  );

  function automatic vec_t v(input logic st, input logic sl, input logic [7:0] op,
                             input logic z, input logic ov, input logic [4:0] nx,
                             input logic [4:0] ea, input logic er, input logic eh,
                             input logic ei, input logic ed, input logic [15:0] ec);
    vec_t r;
    r.start = st; r.stall = sl; r.op = op; r.z = z; r.ovr = ov; r.nxt = nx;
    r.exp.addr = ea; r.exp.run = er; r.exp.halt = eh; r.exp.ill = ei;
    r.exp.disp = ed; r.exp.cnt = ec;
    return r;
  endfunction

  function automatic exp_t e(input logic [4:0] ea, input logic er, input logic eh,
                             input logic ei, input logic ed, input logic [15:0] ec);
    exp_t r;
    r.addr = ea; r.run = er; r.halt = eh; r.ill = ei; r.disp = ed; r.cnt = ec;
    return r;
  endfunction

  task automatic compare(input string name, input int idx);
    exp_t ex;
    exp_t act;
    act = '{addr: addr, run: running, halt: halted, ill: illegal_op,
            disp: dispatch, cnt: instr_count};
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s[%0d]: scoreboard empty, actual addr=%0d", name, idx, addr);
    end else begin
      ex = sb.pop_front();
      if (act === ex) begin
        n_pass++;
      end else begin
        $display("FAIL %s[%0d]: actual addr=%0d run=%0b halt=%0b ill=%0b disp=%0b cnt=%0d, expected addr=%0d run=%0b halt=%0b ill=%0b disp=%0b cnt=%0d",
                 name, idx, act.addr, act.run, act.halt, act.ill, act.disp, act.cnt,
                 ex.addr, ex.run, ex.halt, ex.ill, ex.disp, ex.cnt);
      end
    end
  endtask

  // Called at a negedge: drive one row, check just after the next posedge.
  task automatic apply(input vec_t r, input string name, input int idx);
    start = r.start; stall = r.stall; opcode = r.op; z_flag = r.z;
    ovr_en = r.ovr; ovr_val = r.nxt;
    sb.push_back(r.exp);
    @(posedge clk);
    #1;
    compare(name, idx);
    @(negedge clk);
  endtask

  task automatic check_sat(input int k, input logic [7:0] want);
    n_total++;
    if (s_cnt === want) n_pass++;
    else $display("FAIL sat_count after %0d dispatches: actual %0d, expected %0d", k, s_cnt, want);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 5'd0;
    rom[0] = 5'd1; rom[3] = 5'd30; rom[10] = 5'd11; rom[11] = 5'd12;
    rom[21] = 5'd22;

    // start stall op z ovr nxt | addr run halt ill disp cnt
    tbl1.push_back(v(1'b1,1'b0,8'h0A,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h0A,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h0A,1'b0,1'b0,5'd0, 5'd18,1'b1,1'b0,1'b0,1'b1,16'd1));
    tbl1.push_back(v(1'b0,1'b0,8'h0A,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd1));
    tbl1.push_back(v(1'b0,1'b0,8'h0A,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd1));
    tbl1.push_back(v(1'b0,1'b0,8'h05,1'b0,1'b0,5'd0, 5'd10,1'b1,1'b0,1'b0,1'b1,16'd2));
    tbl1.push_back(v(1'b1,1'b0,8'h05,1'b1,1'b0,5'd0, 5'd11,1'b1,1'b0,1'b0,1'b0,16'd2));
    tbl1.push_back(v(1'b0,1'b0,8'h05,1'b1,1'b0,5'd0, 5'd12,1'b1,1'b0,1'b0,1'b0,16'd2));
    tbl1.push_back(v(1'b0,1'b0,8'h05,1'b1,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd2));
    tbl1.push_back(v(1'b0,1'b0,8'h05,1'b1,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd2));
    tbl1.push_back(v(1'b0,1'b0,8'h05,1'b1,1'b0,5'd0, 5'd13,1'b1,1'b0,1'b0,1'b1,16'd3));
    tbl1.push_back(v(1'b0,1'b0,8'h05,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd3));
    tbl1.push_back(v(1'b0,1'b0,8'h0D,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd3));
    tbl1.push_back(v(1'b0,1'b0,8'h0D,1'b0,1'b0,5'd0, 5'd21,1'b1,1'b0,1'b0,1'b1,16'd4));
    tbl1.push_back(v(1'b0,1'b1,8'h0D,1'b0,1'b0,5'd0, 5'd21,1'b1,1'b0,1'b0,1'b0,16'd4));
    tbl1.push_back(v(1'b1,1'b1,8'h0D,1'b0,1'b0,5'd0, 5'd21,1'b1,1'b0,1'b0,1'b0,16'd4));
    tbl1.push_back(v(1'b0,1'b1,8'h0D,1'b0,1'b0,5'd0, 5'd21,1'b1,1'b0,1'b0,1'b0,16'd4));
    tbl1.push_back(v(1'b0,1'b0,8'h0D,1'b0,1'b0,5'd0, 5'd22,1'b1,1'b0,1'b0,1'b0,16'd4));
    tbl1.push_back(v(1'b0,1'b0,8'h3F,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd4));
    tbl1.push_back(v(1'b0,1'b0,8'h3F,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd4));
    tbl1.push_back(v(1'b0,1'b0,8'h3F,1'b0,1'b0,5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b1,16'd5));
    tbl1.push_back(v(1'b0,1'b1,8'h3F,1'b0,1'b0,5'd0, 5'd0, 1'b0,1'b1,1'b0,1'b0,16'd5));
    tbl1.push_back(v(1'b1,1'b0,8'h2A,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h2A,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h2A,1'b0,1'b0,5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h02,1'b0,1'b0,5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,16'd0));
    tbl1.push_back(v(1'b1,1'b0,8'h02,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h02,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h02,1'b0,1'b0,5'd0, 5'd3, 1'b1,1'b0,1'b0,1'b1,16'd1));
    tbl1.push_back(v(1'b0,1'b0,8'h08,1'b0,1'b0,5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,16'd1));
    tbl1.push_back(v(1'b1,1'b0,8'h08,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h08,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl1.push_back(v(1'b0,1'b0,8'h08,1'b0,1'b0,5'd0, 5'd16,1'b1,1'b0,1'b0,1'b1,16'd1));

    // Boundary of the populated ROM range and the remaining map corners.
    tbl2.push_back(v(1'b1,1'b0,8'h10,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl2.push_back(v(1'b0,1'b0,8'h10,1'b0,1'b1,5'd26,5'd26,1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl2.push_back(v(1'b0,1'b0,8'h10,1'b0,1'b1,5'd27,5'd0, 1'b0,1'b1,1'b1,1'b0,16'd0));
    tbl2.push_back(v(1'b1,1'b0,8'h10,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl2.push_back(v(1'b0,1'b0,8'h10,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd0));
    tbl2.push_back(v(1'b0,1'b0,8'h10,1'b0,1'b0,5'd0, 5'd26,1'b1,1'b0,1'b0,1'b1,16'd1));
    tbl2.push_back(v(1'b0,1'b0,8'h00,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,16'd1));
    tbl2.push_back(v(1'b0,1'b0,8'h00,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd1));
    tbl2.push_back(v(1'b0,1'b0,8'h00,1'b0,1'b0,5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,16'd2));
    tbl2.push_back(v(1'b0,1'b0,8'h0A,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd2));
    tbl2.push_back(v(1'b0,1'b1,8'h0A,1'b0,1'b0,5'd0, 5'd1, 1'b1,1'b0,1'b0,1'b0,16'd2));
    tbl2.push_back(v(1'b0,1'b0,8'h0E,1'b0,1'b1,5'd31,5'd23,1'b1,1'b0,1'b0,1'b1,16'd3));

    // Reset state while rst is held across clock edges.
    repeat (2) @(negedge clk);
    sb.push_back(e(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    compare("reset", 0);
    rst = 1'b0;

    foreach (tbl1[i]) apply(tbl1[i], "run", i);

    // Asynchronous reset mid-instruction (addr=16), checked before any edge.
    #2 rst = 1'b1;
    #1;
    sb.push_back(e(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    compare("async_rst", 0);
    @(negedge clk);
    sb.push_back(e(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    compare("async_rst", 1);
    start = 1'b0; stall = 1'b0; ovr_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    sb.push_back(e(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    compare("idle_hold", 0);

    foreach (tbl2[i]) apply(tbl2[i], "edge", i);

    // Saturation: opcode 00 dispatches every second cycle (0 -> 1 -> 0 ...).
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      if (k == 1)   check_sat(k, 8'd1);
      if (k == 254) check_sat(k, 8'hFE);
      if (k == 255) check_sat(k, 8'hFF);
      if (k == 300) check_sat(k, 8'hFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
